// File: rtl/sram_single_port.sv
// Single-port synchronous RAM: shared address, write-priority enables,
// registered read data, synchronous clear of array and output register.
module sram_single_port #(
    parameter int unsigned depth = 10,
    parameter int unsigned width = 8,
    localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] data_in,
    input  logic [AW-1:0]    add,
    input  logic             we,
    input  logic             re,
    output logic [width-1:0] data_out
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(depth);

    logic [width-1:0] mem [depth];
    logic             in_range_c;

    // Addresses at or beyond depth exist when depth is not a power of two.
    assign in_range_c = ({1'b0, add} < DEPTH_V);

    // Reset overrides everything; a write suppresses a concurrent read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(depth); i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else if (we) begin
            if (in_range_c) begin
                mem[add] <= data_in;
            end
        end else if (re) begin
            data_out <= in_range_c ? mem[add] : '0;
        end
    end

endmodule

// File: tb/tb_sram_single_port.sv
// Scenario bench for sram_single_port: expected data_out values are queued
// as each cycle is driven and compared one edge later.
module tb_sram_single_port;

    localparam int unsigned DEPTH = 10;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 4;

    typedef struct packed {
        logic             rs;
        logic             w;
        logic             r;
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] e;
    } op_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic [AW-1:0]    add = '0;
    logic             we = 1'b0;
    logic             re = 1'b0;
    logic [WIDTH-1:0] data_out;

    logic [WIDTH-1:0] exp_q [$];
    int               checks = 0;
    int               fails  = 0;

    sram_single_port #(.depth(DEPTH), .width(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .add      (add),
        .we       (we),
        .re       (re),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Drive one cycle on the falling edge, return just after the rising edge.
    task automatic cycle(input op_t op);
        @(negedge clk);
        rst     = op.rs;
        we      = op.w;
        re      = op.r;
        add     = op.a;
        data_in = op.d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        op_t ops [3];
        logic [WIDTH-1:0] e;
        ops = '{'{1'b1, 1'b1, 1'b0, 4'd3, 8'hAA, 8'h00},
                '{1'b1, 1'b1, 1'b0, 4'd3, 8'hAA, 8'h00},
                '{1'b0, 1'b0, 1'b1, 4'd3, 8'h00, 8'h00}};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ops[i].e);
            cycle(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e) begin
                fails++;
                $display("FAIL reset step %0d: data_out=%h expected %h", i, data_out, e);
            end
        end
    endtask

    task automatic test_basic();
        op_t ops [4];
        logic [WIDTH-1:0] e;
        ops = '{'{1'b0, 1'b1, 1'b0, 4'd0, 8'd25, 8'd0},
                '{1'b0, 1'b0, 1'b0, 4'd0, 8'd0,  8'd0},
                '{1'b0, 1'b0, 1'b1, 4'd0, 8'd0,  8'd25},
                '{1'b0, 1'b0, 1'b0, 4'd0, 8'd0,  8'd25}};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ops[i].e);
            cycle(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e) begin
                fails++;
                $display("FAIL basic step %0d: data_out=%h expected %h", i, data_out, e);
            end
        end
    endtask

    task automatic test_sweep();
        op_t op;
        logic [WIDTH-1:0] e;
        for (int i = 0; i < 2 * int'(DEPTH); i++) begin
            if (i < int'(DEPTH)) begin
                op = '{1'b0, 1'b1, 1'b0, AW'(i), WIDTH'(8'h10 + i), 8'd25};
            end else begin
                op = '{1'b0, 1'b0, 1'b1, AW'(i - int'(DEPTH)), 8'h00,
                       WIDTH'(8'h10 + i - int'(DEPTH))};
            end
            exp_q.push_back(op.e);
            cycle(op);
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e) begin
                fails++;
                $display("FAIL sweep step %0d: data_out=%h expected %h", i, data_out, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        op_t ops [4];
        logic [WIDTH-1:0] e;
        ops = '{'{1'b0, 1'b1, 1'b0, 4'd2, 8'h55, 8'h19},
                '{1'b0, 1'b0, 1'b1, 4'd2, 8'h00, 8'h55},
                '{1'b0, 1'b1, 1'b1, 4'd2, 8'h77, 8'h55},
                '{1'b0, 1'b0, 1'b1, 4'd2, 8'h00, 8'h77}};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ops[i].e);
            cycle(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e) begin
                fails++;
                $display("FAIL simultaneous step %0d: data_out=%h expected %h", i, data_out, e);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [WIDTH-1:0] known [DEPTH];
        op_t op;
        logic [WIDTH-1:0] e;
        for (int i = 0; i < int'(DEPTH); i++) known[i] = WIDTH'(8'h10 + i);
        known[2] = 8'h77;
        op = '{1'b0, 1'b1, 1'b0, 4'd12, 8'hEE, 8'h77};
        exp_q.push_back(op.e);
        cycle(op);
        op = '{1'b0, 1'b1, 1'b0, 4'd15, 8'hEE, 8'h77};
        exp_q.push_back(op.e);
        cycle(op);
        op = '{1'b0, 1'b0, 1'b1, 4'd12, 8'h00, 8'h00};
        exp_q.push_back(op.e);
        cycle(op);
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (k == 2 && data_out !== e) begin
                fails++;
                $display("FAIL oor_read12: data_out=%h expected %h", data_out, e);
            end else if (k < 2 && e !== 8'h77) begin
                fails++;
                $display("FAIL oor_queue %0d: entry=%h expected 77", k, e);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            op = '{1'b0, 1'b0, 1'b1, AW'(i), 8'h00, known[i]};
            exp_q.push_back(op.e);
            cycle(op);
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e) begin
                fails++;
                $display("FAIL oor_preserve addr %0d: data_out=%h expected %h", i, data_out, e);
            end
        end
        op = '{1'b0, 1'b0, 1'b1, 4'd15, 8'h00, 8'h00};
        exp_q.push_back(op.e);
        cycle(op);
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e) begin
            fails++;
            $display("FAIL oor_read15: data_out=%h expected %h", data_out, e);
        end
    endtask

    task automatic test_reset_midstream();
        op_t ops [5];
        logic [WIDTH-1:0] e;
        ops = '{'{1'b0, 1'b0, 1'b1, 4'd9, 8'h00, 8'h19},
                '{1'b0, 1'b1, 1'b0, 4'd5, 8'h33, 8'h19},
                '{1'b1, 1'b1, 1'b0, 4'd6, 8'h44, 8'h00},
                '{1'b0, 1'b0, 1'b1, 4'd5, 8'h00, 8'h00},
                '{1'b0, 1'b0, 1'b1, 4'd6, 8'h00, 8'h00}};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ops[i].e);
            cycle(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e) begin
                fails++;
                $display("FAIL reset_midstream step %0d: data_out=%h expected %h", i, data_out, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops [6];
        logic [WIDTH-1:0] e;
        ops = '{'{1'b0, 1'b1, 1'b0, 4'd4, 8'hA1, 8'h00},
                '{1'b0, 1'b0, 1'b1, 4'd4, 8'h00, 8'hA1},
                '{1'b0, 1'b1, 1'b0, 4'd4, 8'hB2, 8'hA1},
                '{1'b0, 1'b0, 1'b1, 4'd4, 8'h00, 8'hB2},
                '{1'b0, 1'b0, 1'b1, 4'd3, 8'h00, 8'h00},
                '{1'b0, 1'b0, 1'b1, 4'd4, 8'h00, 8'hB2}};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ops[i].e);
            cycle(ops[i]);
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e) begin
                fails++;
                $display("FAIL back_to_back step %0d: data_out=%h expected %h", i, data_out, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_simultaneous();
        test_out_of_range();
        test_reset_midstream();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
